bcam_rw: RTL and testbench
==========================

Name: bcam_rw

Overview:
- Parametrised binary CAM with a runtime write/invalidate port, per-entry valid bits, and a pipelined match path with a lowest-index priority encoder.
- Also reports multi-hit, hit count and first-free entry.
- Sits in the router header-lookup path; the packet parser issues searches and the control plane populates entries at runtime.

Parameters:
- KEY_W, 32, key/entry width in bits
- DEPTH, 512, number of entries (power of two, >=4)
- ADDR_W, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request: store wr_key at wr_addr, set valid
- inv_en  in  1  invalidate request: clear valid of wr_addr
- wr_addr  in  ADDR_W  target entry for write/invalidate
- wr_key  in  KEY_W  key to store
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  entry to read
- rd_key  out  KEY_W  stored key (0 if entry invalid or rd_en low last cycle)
- rd_valid  out  1  valid bit of the entry read
- srch_en  in  1  search request, one key per cycle
- srch_key  in  KEY_W  key to search
- match_vld  out  1  result strobe for a search issued 2 cycles earlier
- match  out  1  at least one valid entry equals the key
- match_addr  out  ADDR_W  lowest matching index (0 when no match)
- multi_hit  out  1  two or more entries matched
- free_addr  out  ADDR_W  lowest invalid index (0 when full)
- full  out  1  all entries valid

Behaviour:
- Reset: all valid bits cleared; array contents are don't-care. All outputs 0 the cycle after reset is sampled, except `full`, which also reads 0 after reset (all entries free).
- Write: `wr_en` at edge N updates the entry and sets its valid bit; the entry is visible to reads and searches sampled at edge N+1 onward.
- Invalidate: `inv_en` clears the valid bit only; the key storage is untouched.
- `wr_en` and `inv_en` both high: write wins.
- Read: 1-cycle latency. `rd_key` and `rd_valid` are registered.
  - If `rd_en` is low, `rd_key` = 0 and `rd_valid` = 0.
  - Reading an invalid entry returns `rd_key` = 0.
- Search pipeline, fully pipelined, accepts one search per cycle:
  - S1 (edge N): compare `srch_key` against all entries ANDed with valid; register a DEPTH-bit hit vector and the `srch_en` flag.
  - S2 (edge N+1): priority-encode the hit vector and register `match`, `match_addr`, `multi_hit` and `match_vld`.
  - Results appear after edge N+1, i.e. latency 2.
  - When the S2 flag is 0, `match_vld`, `match`, `match_addr` and `multi_hit` are 0.
- Collision: a search and a write to the same entry at the same edge compare against the pre-write contents and valid bit (old data).
- Reset mid-pipeline: the S1/S2 valid flags are cleared, so no `match_vld` pulse emerges for searches in flight.
- `free_addr` / `full`:
  - Registered, combinationally derived from the valid bits, so they reflect writes 1 cycle later.
  - `full` = AND of all valid bits. When `full`, `free_addr` = 0.
- `multi_hit`: set when the popcount of the hit vector is >=2. It must not need a full popcount adder; any-two detection is sufficient.
- All comparisons are exact on KEY_W bits; no arithmetic overflow paths exist.

Optional Feature:
- Macro BCAM_RW_MASK_EN.
- Defined:
  - Adds input `srch_mask` [KEY_W-1:0], sampled with `srch_key`.
  - Bit = 1 means don't-care; compare is ((entry ^ key) & ~mask) == 0.
  - All-ones mask matches every valid entry.
- Undefined: the port is absent and the compare is exact.
- Latency and collision rules are identical with and without the macro.

Decomposition:
- Package bcam_pkg holds:
  - default KEY_W/DEPTH constants
  - a typedef for the search-result struct {match, multi_hit, addr}
  - a function computing ADDR_W
- Sub-module bcam_prio_enc (parameter DEPTH): DEPTH-bit vector in; outputs any, multi, and lowest index out; purely combinational. It is instantiated twice: once on the hit vector, and once on the inverted valid vector for `free_addr`.

Test Plan:
- Reset, then write 0xDEADBEEF@5 and 0x12345678@9; search 0x12345678 -> 2 cycles later `match_vld`=1, `match`=1, `match_addr`=9, `multi_hit`=0.
- Write 0xAAAA0000@3 and @7; search 0xAAAA0000 -> `match_addr`=3, `multi_hit`=1. Invalidate 3; search again -> `match_addr`=7, `multi_hit`=0.
- Back-to-back searches for 0xDEADBEEF, 0x0, 0x12345678 on consecutive cycles -> three consecutive `match_vld` pulses with results (5,1), (0,0), (9,1).
- Same-edge write 0x55@4 and search 0x55 -> `match`=0; a search on the next cycle -> `match`=1, `match_addr`=4.
- Fill all DEPTH entries -> `full`=1, `free_addr`=0. Invalidate entry 100 -> the cycle after, `full`=0 and `free_addr`=100. `rd_en`@100 -> `rd_valid`=0, `rd_key`=0.
- Assert reset while two searches are in flight -> no `match_vld` pulse follows. Subsequent search for an earlier key -> `match`=0 (valid bits cleared).

Source files
------------

// File: rtl/bcam_pkg.sv
// bcam_pkg: shared constants, search-result type and width helper for bcam_rw.
//   KEY_W_DEF / DEPTH_DEF : default key width and entry count
//   ADDR_MAX_W            : widest entry index the result struct can carry
//   srch_res_t            : {match, multi_hit, addr} produced by the search pipeline
//   calc_addr_w()         : index width for a given entry count
package bcam_pkg;

  localparam int KEY_W_DEF  = 32;
  localparam int DEPTH_DEF  = 512;
  localparam int ADDR_MAX_W = 16;

  typedef struct packed {
    logic                  match;
    logic                  multi_hit;
    logic [ADDR_MAX_W-1:0] addr;
  } srch_res_t;

  // Smallest w with 2**w >= depth, never less than 1.
  function automatic int calc_addr_w(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      w = ((32'sd1 << i) < depth) ? (i + 1) : w;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcam_prio_enc.sv
// bcam_prio_enc: purely combinational lowest-index priority encoder.
//   vec_in    in  DEPTH   request vector
//   any_hit   out 1       at least one bit set
//   multi_hit out 1       two or more bits set (any-two detect, no popcount)
//   low_idx   out ADDR_W  index of the lowest set bit, 0 when none
module bcam_prio_enc
  import bcam_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = calc_addr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec_in,
  output logic              any_hit,
  output logic              multi_hit,
  output logic [ADDR_W-1:0] low_idx
);

  // Ascending scan: the first set bit latches the index, any later set bit
  // while one has already been seen flags a multi-hit.
  always_comb begin
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    low_idx   = {ADDR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      multi_hit = multi_hit | (any_hit & vec_in[i]);
      low_idx   = (vec_in[i] && !any_hit) ? ADDR_W'(i) : low_idx;
      any_hit   = any_hit | vec_in[i];
    end
  end

endmodule

// File: rtl/bcam_rw.sv
// bcam_rw: binary CAM with runtime write/invalidate, registered read port and a
// two-stage search pipeline (compare -> priority encode), plus free-slot tracking.
//   clk, reset                : clock, synchronous active-high reset
//   wr_en/inv_en/wr_addr/wr_key : write (sets valid) / invalidate (clears valid); write wins
//   rd_en/rd_addr -> rd_key/rd_valid : 1-cycle registered read, zero when idle or invalid
//   srch_en/srch_key -> match_vld/match/match_addr/multi_hit : latency-2 search
//   free_addr/full            : lowest invalid entry / all entries valid (registered)
// Optional macro BCAM_RW_MASK_EN adds srch_mask (1 = don't-care bit in the compare).
module bcam_rw
  import bcam_pkg::*;
#(
  parameter  int KEY_W  = KEY_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = calc_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_key,
  output logic              rd_valid,
  input  logic              srch_en,
  input  logic [KEY_W-1:0]  srch_key,
`ifdef BCAM_RW_MASK_EN
  input  logic [KEY_W-1:0]  srch_mask,
`endif
  output logic              match_vld,
  output logic              match,
  output logic [ADDR_W-1:0] match_addr,
  output logic              multi_hit,
  output logic [ADDR_W-1:0] free_addr,
  output logic              full
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [KEY_W-1:0]  mem_q [DEPTH];
  logic [KEY_W-1:0]  mem_d [DEPTH];
  logic [KEY_W-1:0]  rd_key_q, rd_key_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DEPTH-1:0]  hit_q, hit_d;
  logic              s1_vld_q, s1_vld_d;
  srch_res_t         res_q, res_d;
  logic              s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0] free_addr_q, free_addr_d;
  logic              full_q, full_d;

  logic [KEY_W-1:0]  mask_s;
  logic              hit_any_s, hit_multi_s;
  logic [ADDR_W-1:0] hit_idx_s;
  logic              free_any_s, unused_free_multi_s;
  logic [ADDR_W-1:0] free_idx_s;
  logic              unused_res_addr_s;

`ifdef BCAM_RW_MASK_EN
  assign mask_s = srch_mask;
`else
  assign mask_s = {KEY_W{1'b0}};
`endif

  // Write port: write takes priority over invalidate; invalidate leaves the key alone.
  always_comb begin
    valid_d = valid_q;
    mem_d   = mem_q;
    if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
      mem_d[wr_addr]   = wr_key;
    end else if (inv_en) begin
      valid_d[wr_addr] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Read port: zero data unless the read is requested and the entry is valid.
  always_comb begin
    rd_valid_d = rd_en ? valid_q[rd_addr] : 1'b0;
    rd_key_d   = (rd_en && valid_q[rd_addr]) ? mem_q[rd_addr] : {KEY_W{1'b0}};
  end

  // Search stage 1: compare against the registered (pre-write) contents, so a
  // same-edge write is not seen by the search.
  always_comb begin
    hit_d    = {DEPTH{1'b0}};
    s1_vld_d = srch_en;
    for (int i = 0; i < DEPTH; i++) begin
      hit_d[i] = srch_en & valid_q[i] &
                 (((mem_q[i] ^ srch_key) & ~mask_s) == {KEY_W{1'b0}});
    end
  end

  bcam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
    .vec_in    (hit_q),
    .any_hit   (hit_any_s),
    .multi_hit (hit_multi_s),
    .low_idx   (hit_idx_s)
  );

  // Search stage 2: encoded result, forced to zero when no search occupies the stage.
  always_comb begin
    s2_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      res_d.match     = hit_any_s;
      res_d.multi_hit = hit_multi_s;
      res_d.addr      = ADDR_MAX_W'(hit_idx_s);
    end else begin
      res_d.match     = 1'b0;
      res_d.multi_hit = 1'b0;
      res_d.addr      = {ADDR_MAX_W{1'b0}};
    end
  end

  // Free-slot tracking runs on the inverted valid vector.
  bcam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
    .vec_in    (~valid_q),
    .any_hit   (free_any_s),
    .multi_hit (unused_free_multi_s),
    .low_idx   (free_idx_s)
  );

  // No free entry means full; the encoder already returns index 0 in that case.
  always_comb begin
    full_d      = ~free_any_s;
    free_addr_d = free_idx_s;
  end

  // Control, pipeline and output registers; reset drops any search in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= {DEPTH{1'b0}};
      rd_key_q    <= {KEY_W{1'b0}};
      rd_valid_q  <= 1'b0;
      hit_q       <= {DEPTH{1'b0}};
      s1_vld_q    <= 1'b0;
      res_q       <= '{match: 1'b0, multi_hit: 1'b0, addr: {ADDR_MAX_W{1'b0}}};
      s2_vld_q    <= 1'b0;
      free_addr_q <= {ADDR_W{1'b0}};
      full_q      <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd_key_q    <= rd_key_d;
      rd_valid_q  <= rd_valid_d;
      hit_q       <= hit_d;
      s1_vld_q    <= s1_vld_d;
      res_q       <= res_d;
      s2_vld_q    <= s2_vld_d;
      free_addr_q <= free_addr_d;
      full_q      <= full_d;
    end
  end

  // Key storage has no reset: entries are meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Upper address bits of the result struct are zero padding.
  assign unused_res_addr_s = ^res_q.addr;

  assign rd_key     = rd_key_q;
  assign rd_valid   = rd_valid_q;
  assign match_vld  = s2_vld_q;
  assign match      = res_q.match;
  assign match_addr = res_q.addr[ADDR_W-1:0];
  assign multi_hit  = res_q.multi_hit;
  assign free_addr  = free_addr_q;
  assign full       = full_q;

endmodule

// File: tb/tb_bcam_rw.sv
// Self-checking bench for bcam_rw (KEY_W=32, DEPTH=512): table-driven operations,
// a search scoreboard checked by a monitor, and hand sequences for fill/reset cases.
module tb_bcam_rw;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, inv_en = 1'b0, rd_en = 1'b0, srch_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0]   wr_key = '0, srch_key = '0;
  logic [31:0]   rd_key;
  logic          rd_valid, match_vld, match, multi_hit, full;
  logic [AW-1:0] match_addr, free_addr;
`ifdef BCAM_RW_MASK_EN
  logic [31:0]   srch_mask = '0;
`endif

  bcam_rw #(.KEY_W(32), .DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .inv_en(inv_en), .wr_addr(wr_addr), .wr_key(wr_key),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_key(rd_key), .rd_valid(rd_valid),
    .srch_en(srch_en), .srch_key(srch_key),
`ifdef BCAM_RW_MASK_EN
    .srch_mask(srch_mask),
`endif
    .match_vld(match_vld), .match(match), .match_addr(match_addr),
    .multi_hit(multi_hit), .free_addr(free_addr), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  typedef struct { logic m; logic [AW-1:0] a; logic mh; int due; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef enum int { OP_IDLE, OP_WR, OP_INV, OP_WRINV, OP_SRCH, OP_WRSRCH, OP_RD } op_e;
  // For OP_RD, key/em hold the expected rd_key/rd_valid.
  typedef struct { op_e op; logic [AW-1:0] addr; logic [31:0] key; logic em; logic [AW-1:0] ea; logic emh; } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Search scoreboard: every result strobe must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (mon_on) begin
      if (match_vld === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_match_vld: got pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.due != cyc || match !== mon_e.m || match_addr !== mon_e.a || multi_hit !== mon_e.mh) begin
            n_err++;
            $display("FAIL search_result: got cyc=%0d m=%0b a=%0d mh=%0b, expected cyc=%0d m=%0b a=%0d mh=%0b",
                     cyc, match, match_addr, multi_hit, mon_e.due, mon_e.m, mon_e.a, mon_e.mh);
          end
        end
      end else begin
        n_vec++;
        if (match !== 1'b0 || match_addr !== '0 || multi_hit !== 1'b0) begin
          n_err++;
          $display("FAIL idle_result: got m=%0b a=%0d mh=%0b, expected all 0 (cycle %0d)",
                   match, match_addr, multi_hit, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          mon_e = exp_q.pop_front();
          n_err++;
          $display("FAIL missing_match_vld: got no pulse at cycle %0d, expected one (due %0d)", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic clr();
    wr_en = 1'b0; inv_en = 1'b0; rd_en = 1'b0; srch_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Drive one operation for one cycle (called at a falling edge).
  task automatic apply(input vec_t v);
    case (v.op)
      OP_WR:     begin wr_en = 1'b1; wr_addr = v.addr; wr_key = v.key; end
      OP_INV:    begin inv_en = 1'b1; wr_addr = v.addr; end
      OP_WRINV:  begin wr_en = 1'b1; inv_en = 1'b1; wr_addr = v.addr; wr_key = v.key; end
      OP_SRCH:   begin srch_en = 1'b1; srch_key = v.key; exp_q.push_back('{v.em, v.ea, v.emh, cyc + 2}); end
      OP_WRSRCH: begin
        wr_en = 1'b1; wr_addr = v.addr; wr_key = v.key;
        srch_en = 1'b1; srch_key = v.key; exp_q.push_back('{v.em, v.ea, v.emh, cyc + 2});
      end
      OP_RD:     begin rd_en = 1'b1; rd_addr = v.addr; end
      default:   begin end
    endcase
    @(negedge clk);
    clr();
    if (v.op == OP_RD) begin
      chk("rd_key", rd_key, v.key);
      chk("rd_valid", 32'(rd_valid), 32'(v.em));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back('{OP_WR,     9'd5, 32'hDEADBEEF, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_WR,     9'd9, 32'h12345678, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'h12345678, 1'b1, 9'd9, 1'b0});
    tbl.push_back('{OP_WR,     9'd3, 32'hAAAA0000, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_WR,     9'd7, 32'hAAAA0000, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'hAAAA0000, 1'b1, 9'd3, 1'b1});
    tbl.push_back('{OP_INV,    9'd3, 32'h0,        1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'hAAAA0000, 1'b1, 9'd7, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'hDEADBEEF, 1'b1, 9'd5, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'h00000000, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'h12345678, 1'b1, 9'd9, 1'b0});
    tbl.push_back('{OP_WRSRCH, 9'd4, 32'h00000055, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'h00000055, 1'b1, 9'd4, 1'b0});
    tbl.push_back('{OP_RD,     9'd9, 32'h12345678, 1'b1, 9'd0, 1'b0});
    tbl.push_back('{OP_RD,     9'd3, 32'h00000000, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_WRINV,  9'd3, 32'h00000077, 1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_SRCH,   9'd0, 32'h00000077, 1'b1, 9'd3, 1'b0});
    tbl.push_back('{OP_RD,     9'd3, 32'h00000077, 1'b1, 9'd0, 1'b0});
    tbl.push_back('{OP_IDLE,   9'd0, 32'h0,        1'b0, 9'd0, 1'b0});
    tbl.push_back('{OP_IDLE,   9'd0, 32'h0,        1'b0, 9'd0, 1'b0});

    // Reset and post-reset output state.
    idle(3);
    reset = 1'b0;
    chk("rst_rd_key", rd_key, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_match_vld", 32'(match_vld), 32'h0);
    chk("rst_match", 32'(match), 32'h0);
    chk("rst_match_addr", 32'(match_addr), 32'h0);
    chk("rst_multi_hit", 32'(multi_hit), 32'h0);
    chk("rst_free_addr", 32'(free_addr), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    mon_on = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Read with rd_en low returns zero.
    chk("rd_idle_key", rd_key, 32'h0);
    chk("rd_idle_valid", 32'(rd_valid), 32'h0);

    // Fill every entry; check the one-cycle lag on full/free_addr at the boundary.
    for (int i = 0; i < 511; i++) apply('{OP_WR, AW'(i), 32'h1000_0000 + i, 1'b0, 9'd0, 1'b0});
    idle(1);
    chk("almost_full", 32'(full), 32'h0);
    chk("last_free", 32'(free_addr), 32'd511);
    apply('{OP_WR, 9'd511, 32'h1000_01FF, 1'b0, 9'd0, 1'b0});
    chk("full_lag", 32'(full), 32'h0);
    idle(1);
    chk("full", 32'(full), 32'h1);
    chk("full_free_addr", 32'(free_addr), 32'h0);
    apply('{OP_INV, 9'd100, 32'h0, 1'b0, 9'd0, 1'b0});
    idle(1);
    chk("inv_full", 32'(full), 32'h0);
    chk("inv_free_addr", 32'(free_addr), 32'd100);
    apply('{OP_RD,   9'd100, 32'h0,         1'b0, 9'd0,   1'b0});
    apply('{OP_RD,   9'd101, 32'h1000_0065, 1'b1, 9'd0,   1'b0});
    apply('{OP_SRCH, 9'd0,   32'h1000_00C8, 1'b1, 9'd200, 1'b0});
    apply('{OP_SRCH, 9'd0,   32'h1000_0064, 1'b0, 9'd0,   1'b0});
    idle(3);

    // Reset with two searches in flight: no result strobe may follow.
    srch_en = 1'b1; srch_key = 32'h1000_000A;
    @(negedge clk);
    srch_key = 32'h1000_0014; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; clr();
    idle(4);
    chk("post_rst_full", 32'(full), 32'h0);
    chk("post_rst_free", 32'(free_addr), 32'h0);
    apply('{OP_SRCH, 9'd0, 32'h1000_000A, 1'b0, 9'd0, 1'b0});
    idle(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
